// File: rtl/mac_learn_table.sv
// Direct-mapped MAC learning/forwarding table: learns src MAC->port, looks up dst MAC, returns egress mask.
// Define MAC_TABLE_AGING_EN to add per-entry age counters and periodic invalidation of stale entries.
module mac_learn_table #(
  parameter int NUM_PORTS   = 4,
  parameter int TABLE_DEPTH = 256,
  parameter int MAC_W       = 48
`ifdef MAC_TABLE_AGING_EN
  ,
  parameter int AGE_W       = 2,
  parameter int AGE_PERIOD  = 1000
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [MAC_W-1:0]             req_src_mac,
  input  logic [MAC_W-1:0]             req_dst_mac,
  input  logic [$clog2(NUM_PORTS)-1:0] req_in_port,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [NUM_PORTS-1:0]         resp_port_mask,
  output logic                         resp_hit,
  input  logic                         flush,
  output logic [15:0]                  overwrite_cnt
);

  localparam int IDX_W     = $clog2(TABLE_DEPTH);
  localparam int PORT_W    = $clog2(NUM_PORTS);
  localparam int NSLICE    = (MAC_W + IDX_W - 1) / IDX_W;
  localparam int MCAST_BIT = 40;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HASH   = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_LEARN  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  function automatic logic [IDX_W-1:0] fold_hash(input logic [MAC_W-1:0] mac);
    logic [NSLICE*IDX_W-1:0] padded;
    logic [IDX_W-1:0]        h;
    padded = (NSLICE*IDX_W)'(mac);
    h      = '0;
    for (int s = 0; s < NSLICE; s++) h = h ^ IDX_W'(padded >> (s * IDX_W));
    return h;
  endfunction

  logic [2:0]           r_state, w_state_nxt;
  logic                 r_req_ready;
  logic [MAC_W-1:0]     r_src, r_dst;
  logic [PORT_W-1:0]    r_in_port;
  logic [IDX_W-1:0]     r_src_idx, r_dst_idx;
  logic [NUM_PORTS-1:0] r_mask;
  logic                 r_hit;
  logic [15:0]          r_ovw_cnt;

  logic [TABLE_DEPTH-1:0] r_valid;
  logic [MAC_W-1:0]       r_mac  [TABLE_DEPTH];
  logic [PORT_W-1:0]      r_port [TABLE_DEPTH];

  logic                 w_accept;
  logic [NUM_PORTS-1:0] w_flood, w_lk_mask;
  logic                 w_lk_hit, w_dst_match;
  logic                 w_src_same, w_learn_en, w_learn_wr, w_refresh, w_ovw;

  assign w_accept = req_valid && r_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_HASH;
      S_HASH:   w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = S_LEARN;
      S_LEARN:  w_state_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Lookup reads the table before this request's own learn, even when src and dst share an index.
  assign w_flood     = ~(NUM_PORTS'(1) << r_in_port);
  assign w_dst_match = r_valid[r_dst_idx] && (r_mac[r_dst_idx] == r_dst);

  always_comb begin
    w_lk_mask = w_flood;
    w_lk_hit  = 1'b0;
    if (!r_dst[MCAST_BIT] && w_dst_match) begin
      w_lk_hit  = 1'b1;
      w_lk_mask = (r_port[r_dst_idx] == r_in_port) ? '0 : (NUM_PORTS'(1) << r_port[r_dst_idx]);
    end
  end

  assign w_src_same = r_valid[r_src_idx] && (r_mac[r_src_idx] == r_src) &&
                      (r_port[r_src_idx] == r_in_port);
  assign w_learn_en = (r_state == S_LEARN) && !r_src[MCAST_BIT];
  assign w_learn_wr = w_learn_en && !w_src_same;
  assign w_refresh  = w_learn_en && w_src_same;
  assign w_ovw      = w_learn_en && r_valid[r_src_idx] && (r_mac[r_src_idx] != r_src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_in_port   <= '0;
      r_src_idx   <= '0;
      r_dst_idx   <= '0;
      r_mask      <= '0;
      r_hit       <= 1'b0;
      r_ovw_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_src     <= req_src_mac;
        r_dst     <= req_dst_mac;
        r_in_port <= req_in_port;
      end
      if (r_state == S_HASH) begin
        r_src_idx <= fold_hash(r_src);
        r_dst_idx <= fold_hash(r_dst);
      end
      if (r_state == S_LOOKUP) begin
        r_mask <= w_lk_mask;
        r_hit  <= w_lk_hit;
      end
      if (w_ovw && (r_ovw_cnt != 16'hFFFF)) r_ovw_cnt <= r_ovw_cnt + 16'd1;
    end
  end

`ifdef MAC_TABLE_AGING_EN
  localparam int CNT_W = $clog2(AGE_PERIOD + 1);

  logic [CNT_W-1:0] r_age_cnt;
  logic             w_tick;
  logic [AGE_W-1:0] r_age [TABLE_DEPTH];

  assign w_tick = (r_age_cnt == CNT_W'(AGE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_age_cnt <= '0;
    else        r_age_cnt <= w_tick ? '0 : r_age_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_tick) begin
      for (int i = 0; i < TABLE_DEPTH; i++) if (r_valid[i]) r_age[i] <= r_age[i] + 1'b1;
    end
    if (w_learn_wr || w_refresh) r_age[r_src_idx] <= '0;
  end
`endif

  // Later assignments win: a learn/refresh overrides a same-cycle age-out, flush overrides both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
`ifdef MAC_TABLE_AGING_EN
      if (w_tick) begin
        for (int i = 0; i < TABLE_DEPTH; i++) if (r_valid[i] && (r_age[i] == '1)) r_valid[i] <= 1'b0;
      end
`endif
      if (w_learn_wr || w_refresh) r_valid[r_src_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_learn_wr) begin
      r_mac[r_src_idx]  <= r_src;
      r_port[r_src_idx] <= r_in_port;
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = (r_state == S_RESP);
  assign resp_port_mask = r_mask;
  assign resp_hit       = r_hit;
  assign overwrite_cnt  = r_ovw_cnt;

endmodule

// File: tb/tb_mac_learn_table.sv
// Directed self-checking bench for mac_learn_table (4 ports, 256 entries; aging steps only with MAC_TABLE_AGING_EN).
module tb_mac_learn_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_src_mac = '0;
  logic [47:0] req_dst_mac = '0;
  logic [1:0]  req_in_port = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [3:0]  resp_port_mask;
  logic        resp_hit;
  logic        flush = 1'b0;
  logic [15:0] overwrite_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [47:0] MAC_A  = 48'h0000_0000_000A;
  localparam logic [47:0] MAC_B  = 48'h0000_0000_000B;
  localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_MC = 48'h0100_5E00_0001;
  localparam logic [47:0] MAC_5E = 48'h0000_0000_005E;
  localparam logic [47:0] MAC_X  = 48'h0000_0000_0033;
  localparam logic [47:0] MAC_Y  = 48'h0000_0000_0132;
  localparam logic [47:0] MAC_Z  = 48'h0000_0000_0077;
  localparam logic [47:0] MAC_W  = 48'h0000_0000_0055;

  always #5 clk = ~clk;

  mac_learn_table #(
    .NUM_PORTS   (4),
    .TABLE_DEPTH (256),
    .MAC_W       (48)
`ifdef MAC_TABLE_AGING_EN
    ,
    .AGE_W       (2),
    .AGE_PERIOD  (10)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_src_mac    (req_src_mac),
    .req_dst_mac    (req_dst_mac),
    .req_in_port    (req_in_port),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_port_mask (resp_port_mask),
    .resp_hit       (resp_hit),
    .flush          (flush),
    .overwrite_cnt  (overwrite_cnt)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. Accept edge t; resp_valid low after t+2, high after t+3.
  task automatic do_req(input string tag, input logic [47:0] src, input logic [47:0] dst,
                        input logic [1:0] inp, input logic [3:0] emask, input logic ehit,
                        input bit hold, input bit fl);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_rdy_timeout: observed req_ready 0 expected 1", tag);
      return;
    end
    req_valid   = 1'b1;
    req_src_mac = src;
    req_dst_mac = dst;
    req_in_port = inp;
    if (hold) resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (fl) flush = 1'b1;
    check({tag, "_early"}, resp_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    check({tag, "_vld"}, resp_valid, 1'b1);
    check({tag, "_mask"}, resp_port_mask, emask);
    check({tag, "_hit"}, resp_hit, ehit);
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        check({tag, "_hold_vld"}, resp_valid, 1'b1);
        check({tag, "_hold_mask"}, resp_port_mask, emask);
        check({tag, "_hold_hit"}, resp_hit, ehit);
        check({tag, "_hold_rdy"}, req_ready, 1'b0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_done"}, resp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mask", resp_port_mask, 4'b0000);
    check("rst_hit", resp_hit, 1'b0);
    check("rst_ovw", overwrite_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1'b1);

    do_req("t1_miss",   MAC_A,  MAC_B,  2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    do_req("t2_hit",    MAC_B,  MAC_A,  2'd2, 4'b0010, 1'b1, 1'b0, 1'b0);
    do_req("t3_bcast",  MAC_MC, MAC_BC, 2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    // 00..5E shares its index with the multicast source; no overwrite means that source was never learned
    do_req("t3_learnB", MAC_5E, MAC_B,  2'd0, 4'b0100, 1'b1, 1'b0, 1'b0);
    check("t3_ovw", overwrite_cnt, 16'd0);
    do_req("t3_hit5E",  MAC_MC, MAC_5E, 2'd2, 4'b0001, 1'b1, 1'b0, 1'b0);

    do_req("t4_move",   MAC_A,  MAC_BC, 2'd3, 4'b0111, 1'b0, 1'b0, 1'b0);
    do_req("t4_filter", MAC_MC, MAC_A,  2'd3, 4'b0000, 1'b1, 1'b1, 1'b0);
    check("t4_ovw", overwrite_cnt, 16'd0);

    do_req("t5_lx",     MAC_X,  MAC_BC, 2'd0, 4'b1110, 1'b0, 1'b0, 1'b0);
    do_req("t5_ly",     MAC_Y,  MAC_BC, 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    check("t5_ovw", overwrite_cnt, 16'd1);
    do_req("t5_qx",     MAC_MC, MAC_X,  2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
    do_req("t5_qy",     MAC_MC, MAC_Y,  2'd2, 4'b0010, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    do_req("t5_flushy", MAC_MC, MAC_Y,  2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);

    do_req("t6_flearn", MAC_Z,  MAC_BC, 2'd1, 4'b1101, 1'b0, 1'b0, 1'b1);
    do_req("t6_qz",     MAC_MC, MAC_Z,  2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);

    do_req("t7_same",   MAC_W,  MAC_W,  2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    do_req("t7_qw",     MAC_MC, MAC_W,  2'd2, 4'b0010, 1'b1, 1'b0, 1'b0);
    check("t7_ovw", overwrite_cnt, 16'd1);

`ifdef MAC_TABLE_AGING_EN
    do_req("ag_learn",  MAC_A,  MAC_BC, 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (15) @(posedge clk);
      #1;
      do_req("ag_refresh", MAC_A, MAC_BC, 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0);
    end
    do_req("ag_alive",  MAC_MC, MAC_A,  2'd2, 4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    do_req("ag_expired", MAC_MC, MAC_A, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
`endif

    req_valid   = 1'b1;
    req_src_mac = 48'h0000_0000_0066;
    req_dst_mac = MAC_BC;
    req_in_port = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", resp_valid, 1'b0);
    check("mid_rst_rdy", req_ready, 1'b0);
    check("mid_rst_ovw", overwrite_cnt, 16'd0);
    check("mid_rst_mask", resp_port_mask, 4'b0000);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_vld_after", resp_valid, 1'b0);
    do_req("rst_cleared", MAC_MC, MAC_W, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
